// File: rtl/game_sequencer_if.sv
// Button inputs and note-engine/compositor outputs of game_sequencer.
interface game_sequencer_if;
  logic        btn_start;
  logic        btn_pause;
  logic [1:0]  scrnum;
  logic        changescr;
  logic [1:0]  countdown;
  logic [12:0] play_time;
  logic        song_done;
  logic        paused;

  modport master (
    input  btn_start, btn_pause,
    output scrnum, changescr, countdown, play_time, song_done, paused
  );

  modport slave (
    output btn_start, btn_pause,
    input  scrnum, changescr, countdown, play_time, song_done, paused
  );
endinterface

// File: rtl/game_sequencer.sv
// Play-flow controller: title, countdown, play, pause, result; drives the note engine.
// Define GAME_PAUSE_EN to build the PAUSE state and btn_pause handling.
module game_sequencer #(
  parameter int unsigned TICK_DIV     = 833333,
  parameter int unsigned COUNT_TICKS  = 120,
  parameter int unsigned SONG_TICKS   = 7200,
  parameter int unsigned RESULT_TICKS = 600
) (
  input logic              clk,
  input logic              rst,
  game_sequencer_if.master bus
);
  localparam int unsigned DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PMAX = (COUNT_TICKS > RESULT_TICKS) ? COUNT_TICKS : RESULT_TICKS;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);
  localparam logic [PW-1:0] COUNT_LAST  = PW'(COUNT_TICKS - 1);
  localparam logic [PW-1:0] RESULT_LAST = PW'(RESULT_TICKS - 1);
  localparam logic [12:0]   SONG_LAST   = 13'(SONG_TICKS - 1);

  typedef enum logic [2:0] {IDLE, COUNT, PLAY, PAUSE, RESULT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [1:0]    scrnum_q, scrnum_nxt;
  logic [1:0]    countdown_q, countdown_nxt;
  logic [12:0]   play_time_q, play_time_nxt;
  logic          changescr_q, changescr_nxt;
  logic          song_done_q, song_done_nxt;
  logic          paused_q, paused_nxt;
  logic          start_q, start_press, pause_press, tick;

  // Previous-sample registers reset high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= 1'b1;
    else     start_q <= bus.btn_start;
  end
  assign start_press = bus.btn_start & ~start_q;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_q <= 1'b1;
    else     pause_q <= bus.btn_pause;
  end
  assign pause_press = bus.btn_pause & ~pause_q;
`else
  logic pause_unused;
  assign pause_unused = bus.btn_pause;
  assign pause_press  = 1'b0;
`endif

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      pcnt        <= '0;
      scrnum_q    <= '0;
      countdown_q <= '0;
      play_time_q <= '0;
      changescr_q <= 1'b0;
      song_done_q <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      div         <= div_nxt;
      pcnt        <= pcnt_nxt;
      scrnum_q    <= scrnum_nxt;
      countdown_q <= countdown_nxt;
      play_time_q <= play_time_nxt;
      changescr_q <= changescr_nxt;
      song_done_q <= song_done_nxt;
      paused_q    <= paused_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    div_nxt       = tick ? '0 : div + 1'b1;
    pcnt_nxt      = pcnt;
    countdown_nxt = countdown_q;
    play_time_nxt = play_time_q;
    changescr_nxt = 1'b0;
    song_done_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_press) begin
          state_nxt     = COUNT;
          countdown_nxt = 2'd3;
          pcnt_nxt      = '0;
          div_nxt       = '0;
          play_time_nxt = '0;
        end
      end
      COUNT: begin
        if (tick) begin
          if (pcnt == COUNT_LAST) begin
            pcnt_nxt      = '0;
            countdown_nxt = countdown_q - 1'b1;
            if (countdown_q == 2'd1) state_nxt = PLAY;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          changescr_nxt = 1'b1;
          play_time_nxt = play_time_q + 1'b1;
        end
        // Song end takes precedence over a pause press on the final tick.
        if (tick && (play_time_q == SONG_LAST)) begin
          state_nxt     = RESULT;
          song_done_nxt = 1'b1;
          pcnt_nxt      = '0;
        end else if (pause_press) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (start_press) begin
          state_nxt = IDLE;
        end else if (pause_press) begin
          state_nxt = PLAY;
          div_nxt   = '0;
        end
      end
      RESULT: begin
        if (start_press) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (pcnt == RESULT_LAST) state_nxt = IDLE;
          else                     pcnt_nxt  = pcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    unique case (state_nxt)
      IDLE:    scrnum_nxt = 2'd0;
      RESULT:  scrnum_nxt = 2'd2;
      default: scrnum_nxt = 2'd1;
    endcase
    paused_nxt = (state_nxt == PAUSE);
  end

  assign bus.scrnum    = scrnum_q;
  assign bus.changescr = changescr_q;
  assign bus.countdown = countdown_q;
  assign bus.play_time = play_time_q;
  assign bus.song_done = song_done_q;
  assign bus.paused    = paused_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4, COUNT_TICKS=2, SONG_TICKS=5, RESULT_TICKS=3.
module tb_game_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses   = 0;

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_DIV(4),
    .COUNT_TICKS(2),
    .SONG_TICKS(5),
    .RESULT_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        pause;
    int unsigned n;
    logic [1:0]  scr;
    logic        cs;
    logic [1:0]  cd;
    logic [12:0] pt;
    logic        sd;
    logic        p;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic s, input logic pa, input int unsigned n,
                              input logic [1:0] scr, input logic cs, input logic [1:0] cd,
                              input logic [12:0] pt, input logic sd, input logic p);
    vec_t v;
    v.start = s; v.pause = pa; v.n = n; v.scr = scr; v.cs = cs;
    v.cd = cd; v.pt = pt; v.sd = sd; v.p = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.changescr === 1'b1) pulses++;
    end
  endtask

  task automatic press_start();
    bus.btn_start = 1'b1;
    step(1);
    bus.btn_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0;
    tbl[0]  = mk(1, 1,  3, 0, 0, 0, 0, 0, 0); // buttons held through reset release
    tbl[1]  = mk(0, 0,  2, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0,  1, 1, 0, 3, 0, 0, 0); // press
    tbl[3]  = mk(0, 0,  7, 1, 0, 3, 0, 0, 0);
    tbl[4]  = mk(0, 0,  1, 1, 0, 2, 0, 0, 0);
    tbl[5]  = mk(0, 0,  7, 1, 0, 2, 0, 0, 0);
    tbl[6]  = mk(0, 0,  1, 1, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0,  7, 1, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0,  1, 1, 0, 0, 0, 0, 0); // PLAY entry
    tbl[9]  = mk(0, 0,  3, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0,  1, 1, 1, 0, 1, 0, 0);
    tbl[11] = mk(0, 0,  1, 1, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0,  3, 1, 1, 0, 2, 0, 0);
    tbl[13] = mk(0, 0,  4, 1, 1, 0, 3, 0, 0);
    tbl[14] = mk(0, 0,  4, 1, 1, 0, 4, 0, 0);
    tbl[15] = mk(0, 0,  3, 1, 0, 0, 4, 0, 0);
    tbl[16] = mk(0, 0,  1, 2, 1, 0, 5, 1, 0); // final pulse with song_done
    tbl[17] = mk(0, 0,  1, 2, 0, 0, 5, 0, 0);
    tbl[18] = mk(0, 0, 10, 2, 0, 0, 5, 0, 0);
    tbl[19] = mk(0, 0,  1, 0, 0, 0, 5, 0, 0); // back to IDLE after 12 cycles

    bus.btn_start = 1'b1;
    bus.btn_pause = 1'b1;
    rst = 1'b1;
    step(2);
    chk("reset scrnum", bus.scrnum, 0);
    chk("reset changescr", bus.changescr, 0);
    chk("reset countdown", bus.countdown, 0);
    chk("reset play_time", bus.play_time, 0);
    chk("reset song_done", bus.song_done, 0);
    chk("reset paused", bus.paused, 0);
    rst = 1'b0;
    pulses = 0;

    for (int i = 0; i < 20; i++) begin
      bus.btn_start = tbl[i].start;
      bus.btn_pause = tbl[i].pause;
      step(tbl[i].n);
      chk($sformatf("row%0d scrnum", i), bus.scrnum, tbl[i].scr);
      chk($sformatf("row%0d changescr", i), bus.changescr, tbl[i].cs);
      chk($sformatf("row%0d countdown", i), bus.countdown, tbl[i].cd);
      chk($sformatf("row%0d play_time", i), bus.play_time, tbl[i].pt);
      chk($sformatf("row%0d song_done", i), bus.song_done, tbl[i].sd);
      chk($sformatf("row%0d paused", i), bus.paused, tbl[i].p);
    end
    chk("song pulse count", pulses, 5);
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;

    // Start press in RESULT exits on the next edge.
    press_start();
    step(44);
    chk("abort-result scrnum before", bus.scrnum, 2);
    chk("abort-result song_done", bus.song_done, 1);
    step(2);
    press_start();
    chk("abort-result scrnum", bus.scrnum, 0);
    chk("abort-result play_time held", bus.play_time, 5);
    step(2);

`ifdef GAME_PAUSE_EN
    press_start();
    chk("pause-run countdown", bus.countdown, 3);
    chk("pause-run play_time cleared", bus.play_time, 0);
    step(24);
    step(8);
    chk("pause-run play_time before pause", bus.play_time, 2);
    p0 = pulses;
    bus.btn_pause = 1'b1;
    step(1);
    bus.btn_pause = 1'b0;
    chk("pause paused", bus.paused, 1);
    step(50);
    chk("pause no pulses", pulses - p0, 0);
    chk("pause play_time held", bus.play_time, 2);
    chk("pause paused held", bus.paused, 1);
    chk("pause scrnum", bus.scrnum, 1);
    bus.btn_pause = 1'b1;
    step(1);
    bus.btn_pause = 1'b0;
    chk("resume paused", bus.paused, 0);
    step(3);
    chk("resume no early pulse", bus.changescr, 0);
    step(1);
    chk("resume pulse", bus.changescr, 1);
    chk("resume play_time", bus.play_time, 3);
    bus.btn_pause = 1'b1;
    step(1);
    bus.btn_pause = 1'b0;
    chk("repause paused", bus.paused, 1);
    step(1);
    bus.btn_start = 1'b1;
    bus.btn_pause = 1'b1;
    step(1);
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    chk("abort-pause scrnum", bus.scrnum, 0);
    chk("abort-pause paused", bus.paused, 0);
    step(2);
    chk("abort-pause stays idle", bus.scrnum, 0);
`else
    // Pause and start presses alternate through PLAY and must not disturb the pulse train.
    press_start();
    step(24);
    chk("nopause play entry countdown", bus.countdown, 0);
    p0 = pulses;
    for (int unsigned k = 1; k <= 20; k++) begin
      bus.btn_pause = k[0];
      bus.btn_start = ~k[0];
      step(1);
      chk($sformatf("nopause c%0d changescr", k), bus.changescr, ((k % 4) == 0) ? 1 : 0);
      chk($sformatf("nopause c%0d paused", k), bus.paused, 0);
    end
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    chk("nopause pulse count", pulses - p0, 5);
    chk("nopause play_time", bus.play_time, 5);
    chk("nopause song_done", bus.song_done, 1);
    chk("nopause scrnum", bus.scrnum, 2);
    step(12);
    chk("nopause back to idle", bus.scrnum, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level play-flow controller for the rhythm game. It walks the game through title, countdown, play, pause and result phases, and drives the note engine. Its outputs to the engine are the screen number `scrnum` and the per-frame advance strobe `changescr`. It sits between the debounced player buttons and the note engine / VGA compositor, and owns all game-phase timing.

## Interface
Parameters:
- `TICK_DIV`, default 833333: clk cycles per frame tick (120 Hz at 100 MHz).
- `COUNT_TICKS`, default 120: ticks per countdown digit.
- `SONG_TICKS`, default 7200: play length in ticks; must be ≤ 8191.
- `RESULT_TICKS`, default 600: ticks the result screen is held.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_start` in 1: debounced, synchronized start button level.
- `btn_pause` in 1: debounced, synchronized pause button level.
- `scrnum` out 2: phase to note engine and compositor.
  - 0 = title (engine held in reset).
  - 1 = countdown, play or pause.
  - 2 = result.
- `changescr` out 1: one-cycle frame-advance strobe; asserted only in PLAY.
- `countdown` out 2: digit 3/2/1 during COUNT; 0 otherwise.
- `play_time` out 13: number of `changescr` pulses issued this song.
- `song_done` out 1: one-cycle pulse when the song ends.
- `paused` out 1: high in PAUSE.

## Operation
- Button presses are rising edges: current input high and previous-sample register low.
  - A press acts on the same edge that first samples it high.
- Tick divider `div` counts 0..`TICK_DIV`-1 and wraps.
  - tick = (`div` == `TICK_DIV`-1).
  - `div` is cleared on entry to COUNT and on PAUSE→PLAY.
- Phase counter `pcnt` counts ticks within COUNT and RESULT. It is cleared on entry to each of those states.

States:
- **IDLE**
  - Outputs: `scrnum`=0, `countdown`=0.
  - start press → COUNT, with `countdown`=3, `pcnt`=0, `div`=0, `play_time`=0.
- **COUNT**
  - Outputs: `scrnum`=1.
  - On each tick `pcnt`++.
  - When a tick lands on `pcnt`==`COUNT_TICKS`-1: `pcnt`←0 and `countdown`--. If `countdown` was 1 → PLAY with `countdown`=0.
  - Buttons are ignored.
- **PLAY**
  - Outputs: `scrnum`=1.
  - On each tick: `changescr`=1 for the next cycle and `play_time`++.
  - On the tick where `play_time`==`SONG_TICKS`-1 → RESULT. That tick still issues its `changescr`; `song_done`=1 for one cycle; `pcnt`=0.
  - pause press → PAUSE.
  - start press is ignored.
  - A pause press on the same edge as a tick: the tick is processed (pulse plus increment) and the state still goes to PAUSE.
- **PAUSE**
  - Outputs: `scrnum`=1, `paused`=1, no `changescr`, `play_time` holds.
  - pause press → PLAY, with `div` cleared.
  - start press → IDLE (abort). If start and pause are pressed on the same edge, start wins.
- **RESULT**
  - Outputs: `scrnum`=2, `play_time` holds.
  - On each tick `pcnt`++. When a tick lands on `pcnt`==`RESULT_TICKS`-1 → IDLE.
  - start press → IDLE immediately.

Widths:
- `div` is $clog2(`TICK_DIV`) bits.
- `pcnt` is sized for max(`COUNT_TICKS`, `RESULT_TICKS`).
- `play_time` never exceeds `SONG_TICKS`, so there is no wrap.

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: `scrnum`=0, `changescr`=0, `countdown`=0, `play_time`=0, `song_done`=0, `paused`=0.
  - Internal: state=IDLE, `div`=0, `pcnt`=0.
  - Button previous-sample registers reset to 1. A button held through reset must be released and pressed again.
- An asserted `rst` overrides everything mid-operation. The engine is reset via `scrnum`=0.
- Phase durations:
  - COUNT lasts exactly 3·`COUNT_TICKS`·`TICK_DIV` cycles.
  - The first `changescr` occurs `TICK_DIV` cycles after PLAY entry.
  - Pulses are `TICK_DIV` cycles apart. A song outside pause produces exactly `SONG_TICKS` pulses.
  - After resume, the next pulse comes `TICK_DIV` cycles after the resume edge.
- Pulse alignment:
  - The final `changescr` and `song_done` are high in the same cycle.
  - `scrnum` is already 2 in that cycle.

## Configuration
- `GAME_PAUSE_EN` defined:
  - The PAUSE state and `btn_pause` handling are built.
- `GAME_PAUSE_EN` undefined:
  - `btn_pause` is ignored and `paused` is tied 0.
  - Start press in PLAY is still ignored.
  - All other behaviour is identical.

## Test plan
All scenarios use `TICK_DIV`=4, `COUNT_TICKS`=2, `SONG_TICKS`=5, `RESULT_TICKS`=3.

- **Reset and held button.** Hold `btn_start` high through `rst` release → stays IDLE with all outputs 0. Release, then press → `countdown`=3 and `scrnum`=1 next cycle.
- **Countdown.** Start press → `countdown` sequence 3,2,1 at 8 cycles each. PLAY entered 24 cycles after the press edge, with `countdown`=0.
- **Play length.** In PLAY → exactly 5 `changescr` pulses, 4 cycles apart, with `play_time` 1..5. The 5th pulse coincides with `song_done`=1 and `scrnum`=2. RESULT returns to IDLE after 12 cycles.
- **Pause and resume.** Pause press after pulse 2 → `paused`=1, no pulses, `play_time`=2 held for 50 cycles. Second pause press → next pulse 4 cycles later with `play_time`=3.
- **Abort and early exit.** Start press in PAUSE → IDLE, `scrnum`=0. Start press in RESULT → IDLE on the next edge.
- **Build without `GAME_PAUSE_EN`.** Pause presses during PLAY → pulse train is unchanged and `paused` stays 0.
